mux_lane_sequencer: RTL

Sequencer that drives the select of the shared 64-to-1 operand mux and serializes a programmable subset of its inputs into a valid/ready stream. On `i_start` it latches a lane mask, walks the set lanes in ascending index order, registers each selected word with its lane index, and pulses `o_done` once the last word has been accepted. It sits between the mux tree (which it controls via `o_sel` and reads via `i_mux_data`) and the downstream consumer.

---
 rtl/mux_lane_sequencer.sv | 114 +++++++++++
 1 files changed

// File: rtl/mux_lane_sequencer.sv
// Walks the set lanes of a latched mask in ascending order, steering the shared
// operand mux through o_sel and streaming each selected word out over valid/ready.
module mux_lane_sequencer #(
    parameter int BIT_WIDTH  = 16,
    parameter int SEL_WIDTH  = 6,
    parameter int NUM_INPUTS = 1 << SEL_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [NUM_INPUTS-1:0] i_mask,
    output logic [SEL_WIDTH-1:0]  o_sel,
    input  logic [BIT_WIDTH-1:0]  i_mux_data,
    output logic [BIT_WIDTH-1:0]  o_data,
    output logic [SEL_WIDTH-1:0]  o_idx,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_INPUTS-1:0] mask_q, mask_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic [BIT_WIDTH-1:0]  data_q, data_d;
    logic [SEL_WIDTH-1:0]  idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic                  can_load;
    logic [NUM_INPUTS-1:0] mask_clr;

    // Priority encoder: lowest set bit wins, zero for an empty vector.
    function automatic logic [SEL_WIDTH-1:0] lowest_set(input logic [NUM_INPUTS-1:0] v);
        lowest_set = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = SEL_WIDTH'(i);
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        sel_d    = sel_q;
        data_d   = data_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        can_load = !valid_q || i_ready;
        mask_clr = mask_q;
        mask_clr[sel_q] = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    mask_d  = i_mask;
                    sel_d   = lowest_set(i_mask);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (can_load) begin
                    if (mask_q != '0) begin
                        // Select only advances while another lane remains, so o_sel
                        // parks on the last emitted lane at the end of a sequence.
                        data_d  = i_mux_data;
                        idx_d   = sel_q;
                        valid_d = 1'b1;
                        mask_d  = mask_clr;
                        if (mask_clr != '0) sel_d = lowest_set(mask_clr);
                    end else begin
                        valid_d = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign o_sel   = sel_q;
    assign o_data  = data_q;
    assign o_idx   = idx_q;
    assign o_valid = valid_q;
    assign o_busy  = (state_q != IDLE);
    assign o_done  = (state_q == DONE);

endmodule
